// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage load/store unit: access size codes,
// controller states, byte-enable patterns and the alignment rule.
package mem_pkg;

  localparam logic [1:0] MEM_B = 2'b00;
  localparam logic [1:0] MEM_H = 2'b01;
  localparam logic [1:0] MEM_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  // Size code 11 is handled as a word, so anything that is not byte or half
  // must be word aligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    case (size)
      MEM_B:   bad = 1'b0;
      MEM_H:   bad = off[0];
      default: bad = (off != 2'b00);
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Load lane extraction: picks the addressed byte or half out of the RAM word
// and sign- or zero-extends it to the full register width.
module load_extend
  import mem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        size,
  input  logic              zero_ext,
  input  logic [1:0]        offset,
  output logic [DATA_W-1:0] result
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Lane select by low address bits, then extend according to access size.
  always_comb begin
    byte_v = rdata[7:0];
    half_v = offset[1] ? rdata[31:16] : rdata[15:0];
    result = rdata;
    case (offset)
      2'd0:    byte_v = rdata[7:0];
      2'd1:    byte_v = rdata[15:8];
      2'd2:    byte_v = rdata[23:16];
      default: byte_v = rdata[31:24];
    endcase
    case (size)
      MEM_B:   result = {{(DATA_W-8){~zero_ext & byte_v[7]}}, byte_v};
      MEM_H:   result = {{(DATA_W-16){~zero_ext & half_v[15]}}, half_v};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit. Runs one req/ack transaction with the data RAM
// per memory instruction, stalls the pipeline while it is outstanding, and
// registers the extended load result for MEM/WB.
// Optional build macro: MEM_MISALIGN_TRAP_EN (misaligned accesses skip the
// RAM and raise misalign_exc instead of silently ignoring low address bits).
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_req_mem,
  input  logic              mem_we_mem,
  input  logic [1:0]        mem_size_mem,
  input  logic              mem_unsigned_mem,
  input  logic [ADDR_W-1:0] alu_c_mem,
  input  logic [DATA_W-1:0] rd2_mem,
  output logic              dram_req,
  output logic              dram_we,
  output logic [ADDR_W-1:0] dram_addr,
  output logic [DATA_W-1:0] dram_wdata,
  output logic [3:0]        dram_be,
  input  logic              dram_ack,
  input  logic [DATA_W-1:0] dram_rdata,
  output logic [DATA_W-1:0] dram_rd_mem,
  output logic              mem_stall,
  output logic              misalign_exc
);

  mem_state_t        state, next_state;
  logic [1:0]        size_r;
  logic              zext_r;
  logic [1:0]        off_r;
  logic [DATA_W-1:0] st_wdata;
  logic [3:0]        st_be;
  logic [DATA_W-1:0] ld_result;
  logic              misaligned;
  logic              accept;

  // A new access can only begin from IDLE; DONE always returns to IDLE first
  // so the still-asserted request of the finishing instruction is not reused.
  assign accept   = (state == IDLE) && mem_req_mem;
  assign dram_req = (state == BUSY);

`ifdef MEM_MISALIGN_TRAP_EN
  assign misaligned = is_misaligned(mem_size_mem, alu_c_mem[1:0]);

  // Exception flag is high only for the DONE cycle that follows a trapped access.
  always_ff @(posedge clk) begin
    if (rst) misalign_exc <= 1'b0;
    else     misalign_exc <= accept && misaligned;
  end
`else
  assign misaligned   = 1'b0;
  assign misalign_exc = 1'b0;
`endif

  // Store lane placement: replicate the data across lanes and enable only the
  // addressed bytes. Half accesses look at addr[1] only, words at neither.
  always_comb begin
    st_wdata = rd2_mem;
    st_be    = BE_WORD;
    case (mem_size_mem)
      MEM_B: begin
        st_wdata = {4{rd2_mem[7:0]}};
        st_be    = BE_BYTE << alu_c_mem[1:0];
      end
      MEM_H: begin
        st_wdata = {2{rd2_mem[15:0]}};
        st_be    = BE_HALF << {alu_c_mem[1], 1'b0};
      end
      default: begin
        st_wdata = rd2_mem;
        st_be    = BE_WORD;
      end
    endcase
  end

  // Controller next state and stall; stall is suppressed while in reset.
  always_comb begin
    next_state = state;
    mem_stall  = 1'b0;
    case (state)
      IDLE: begin
        if (mem_req_mem) begin
          mem_stall  = 1'b1;
          next_state = misaligned ? DONE : BUSY;
        end
      end
      BUSY: begin
        mem_stall = 1'b1;
        if (dram_ack) next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (rst) mem_stall = 1'b0;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Request capture on accept, and load-result register updated on ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      dram_we     <= 1'b0;
      dram_addr   <= '0;
      dram_wdata  <= '0;
      dram_be     <= '0;
      size_r      <= MEM_B;
      zext_r      <= 1'b0;
      off_r       <= 2'b00;
      dram_rd_mem <= '0;
    end else begin
      if (accept && !misaligned) begin
        dram_we    <= mem_we_mem;
        dram_addr  <= {alu_c_mem[ADDR_W-1:2], 2'b00};
        dram_wdata <= st_wdata;
        dram_be    <= st_be;
        size_r     <= mem_size_mem;
        zext_r     <= mem_unsigned_mem;
        off_r      <= alu_c_mem[1:0];
      end
      if (accept && misaligned) begin
        dram_rd_mem <= '0;
      end else if ((state == BUSY) && dram_ack) begin
        dram_rd_mem <= dram_we ? '0 : ld_result;
      end
    end
  end

  load_extend #(
    .DATA_W(DATA_W)
  ) u_load_extend (
    .rdata   (dram_rdata),
    .size    (size_r),
    .zero_ext(zext_r),
    .offset  (off_r),
    .result  (ld_result)
  );

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a byte-level memory model predicts
// every RAM request and every load result; a RAM responder and a result
// monitor compare what the DUT actually presents.
module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic        mem_req_mem;
  logic        mem_we_mem;
  logic [1:0]  mem_size_mem;
  logic        mem_unsigned_mem;
  logic [31:0] alu_c_mem;
  logic [31:0] rd2_mem;
  logic        dram_req;
  logic        dram_we;
  logic [31:0] dram_addr;
  logic [31:0] dram_wdata;
  logic [3:0]  dram_be;
  logic        dram_ack;
  logic [31:0] dram_rdata;
  logic [31:0] dram_rd_mem;
  logic        mem_stall;
  logic        misalign_exc;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          waits;
  } req_t;

  typedef struct {
    logic [31:0] rd;
    logic        exc;
    int          stall;
  } res_t;

  req_t req_q[$];
  res_t res_q[$];

  bit [31:0] ram [bit [31:0]];
  bit [7:0]  model_mem [bit [31:0]];
  logic [31:0] last_rd;

  int  vectors;
  int  miscompares;
  bit  ram_hold;
  bit  late_ack;

  mem_access_unit dut (
    .clk             (clk),
    .rst             (rst),
    .mem_req_mem     (mem_req_mem),
    .mem_we_mem      (mem_we_mem),
    .mem_size_mem    (mem_size_mem),
    .mem_unsigned_mem(mem_unsigned_mem),
    .alu_c_mem       (alu_c_mem),
    .rd2_mem         (rd2_mem),
    .dram_req        (dram_req),
    .dram_we         (dram_we),
    .dram_addr       (dram_addr),
    .dram_wdata      (dram_wdata),
    .dram_be         (dram_be),
    .dram_ack        (dram_ack),
    .dram_rdata      (dram_rdata),
    .dram_rd_mem     (dram_rd_mem),
    .mem_stall       (mem_stall),
    .misalign_exc    (misalign_exc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit [7:0] model_byte(input bit [31:0] a);
    if (model_mem.exists(a)) return model_mem[a];
    return 8'h00;
  endfunction

  task automatic preload(input bit [31:0] word_addr, input bit [31:0] value);
    ram[word_addr] = value;
    for (int i = 0; i < 4; i++) model_mem[word_addr + i] = value[8*i +: 8];
  endtask

  // Issue one memory instruction, predict its effects, and hold it until DONE.
  task automatic apply_stimulus(input logic we, input logic [1:0] size, input logic zext,
                                input logic [31:0] addr, input logic [31:0] data, input int waits);
    int          nbytes;
    int          off;
    bit          mis;
    bit          trap;
    bit [31:0]   word;
    logic [31:0] val;
    req_t        r;
    res_t        s;
    bit          done;

    nbytes = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    mis    = (nbytes == 2 && addr[0]) || (nbytes == 4 && addr[1:0] != 2'b00);
`ifdef MEM_MISALIGN_TRAP_EN
    trap = mis;
`else
    trap = 1'b0;
`endif
    off  = (nbytes == 1) ? int'(addr[1:0]) : (nbytes == 2) ? 2 * int'(addr[1]) : 0;
    word = {addr[31:2], 2'b00};

    if (trap) begin
      s.rd = 32'h0; s.exc = 1'b1; s.stall = 1;
      last_rd = 32'h0;
    end else begin
      r.addr = word; r.we = we; r.waits = waits;
      r.be = 4'b0000;
      for (int i = 0; i < nbytes; i++) r.be[off + i] = 1'b1;
      r.wdata = (nbytes == 1) ? {4{data[7:0]}} : (nbytes == 2) ? {2{data[15:0]}} : data;
      if (we) begin
        for (int i = 0; i < nbytes; i++) model_mem[word + off + i] = data[8*i +: 8];
        val = 32'h0;
      end else begin
        val = 32'h0;
        for (int i = 0; i < nbytes; i++) val[8*i +: 8] = model_byte(word + off + i);
        if (!zext && nbytes < 4 && val[8*nbytes-1]) val = val | (32'hFFFF_FFFF << (8*nbytes));
      end
      req_q.push_back(r);
      s.rd = val; s.exc = 1'b0; s.stall = waits + 2;
      last_rd = val;
    end
    res_q.push_back(s);

    mem_req_mem      = 1'b1;
    mem_we_mem       = we;
    mem_size_mem     = size;
    mem_unsigned_mem = zext;
    alu_c_mem        = addr;
    rd2_mem          = data;

    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (!mem_stall) done = 1'b1;
    end
    if (!done) check_output("done_timeout", 32'(mem_stall), 32'h0);
    @(posedge clk);
    #1;
  endtask

  // Idle cycles between instructions: nothing requested, result held.
  task automatic idle_gap(input int n);
    mem_req_mem = 1'b0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      check_output("gap_stall", 32'(mem_stall), 32'h0);
      check_output("gap_req", 32'(dram_req), 32'h0);
      check_output("gap_exc", 32'(misalign_exc), 32'h0);
      check_output("gap_rd_hold", dram_rd_mem, last_rd);
      @(posedge clk);
      #1;
    end
  endtask

  // RAM responder: checks each request against the expected queue, keeps it
  // stable while waiting, then acks with read data or commits the write.
  initial begin : ram_responder
    req_t cur;
    bit   active;
    int   wait_left;
    dram_ack   = 1'b0;
    dram_rdata = 32'h0;
    active     = 1'b0;
    wait_left  = 0;
    forever begin
      @(negedge clk);
      dram_ack = 1'b0;
      if (late_ack) begin
        dram_ack   = 1'b1;
        dram_rdata = 32'hDEAD_BEEF;
        late_ack   = 1'b0;
      end else if (rst) begin
        active = 1'b0;
      end else if (dram_req && !ram_hold) begin
        if (!active) begin
          if (req_q.size() == 0) begin
            check_output("unexpected_request", 32'(dram_req), 32'h0);
          end else begin
            cur       = req_q.pop_front();
            active    = 1'b1;
            wait_left = cur.waits;
            check_output("req_addr", dram_addr, cur.addr);
            check_output("req_we", 32'(dram_we), 32'(cur.we));
            if (cur.we) begin
              check_output("req_wdata", dram_wdata, cur.wdata);
              check_output("req_be", 32'(dram_be), 32'(cur.be));
            end
          end
        end else begin
          check_output("req_addr_stable", dram_addr, cur.addr);
          check_output("req_we_stable", 32'(dram_we), 32'(cur.we));
        end
        if (active) begin
          if (wait_left == 0) begin
            if (cur.we) begin
              for (int i = 0; i < 4; i++)
                if (dram_be[i]) ram[dram_addr][8*i +: 8] = dram_wdata[8*i +: 8];
            end else begin
              dram_rdata = ram.exists(dram_addr) ? ram[dram_addr] : 32'h0;
            end
            dram_ack = 1'b1;
            active   = 1'b0;
          end else begin
            wait_left--;
          end
        end
      end
    end
  end

  // Result monitor: at each DONE cycle compare load data, exception flag
  // and the number of stalled cycles against the scoreboard.
  initial begin : result_monitor
    res_t exp_r;
    int   stall_cnt;
    stall_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_cnt = 0;
      end else if (mem_stall) begin
        stall_cnt++;
      end else if (mem_req_mem) begin
        if (res_q.size() == 0) begin
          check_output("unexpected_done", 32'(mem_req_mem), 32'h0);
        end else begin
          exp_r = res_q.pop_front();
          check_output("rd_mem", dram_rd_mem, exp_r.rd);
          check_output("misalign_exc", 32'(misalign_exc), 32'(exp_r.exc));
          check_output("stall_cycles", 32'(stall_cnt), 32'(exp_r.stall));
        end
        stall_cnt = 0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    vectors          = 0;
    miscompares      = 0;
    ram_hold         = 1'b0;
    late_ack         = 1'b0;
    last_rd          = 32'h0;
    rst              = 1'b1;
    mem_req_mem      = 1'b1;
    mem_we_mem       = 1'b0;
    mem_size_mem     = 2'b10;
    mem_unsigned_mem = 1'b0;
    alu_c_mem        = 32'h0000_1000;
    rd2_mem          = 32'h0;

    preload(32'h0000_1000, 32'h80FF_1234);
    preload(32'h0000_2000, 32'hBEEF_0000);
    preload(32'h0000_5000, 32'h1357_9BDF);
    for (int w = 1; w < 16; w++) preload(32'h0000_1000 + 32'(4*w), $urandom);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("rst_req", 32'(dram_req), 32'h0);
    check_output("rst_we", 32'(dram_we), 32'h0);
    check_output("rst_addr", dram_addr, 32'h0);
    check_output("rst_wdata", dram_wdata, 32'h0);
    check_output("rst_be", 32'(dram_be), 32'h0);
    check_output("rst_rd_mem", dram_rd_mem, 32'h0);
    check_output("rst_exc", 32'(misalign_exc), 32'h0);
    check_output("rst_stall_forced", 32'(mem_stall), 32'h0);
    @(posedge clk);
    #1;
    rst         = 1'b0;
    mem_req_mem = 1'b0;
    idle_gap(1);

    // lb 0x1003 with two wait cycles, lhu 0x2002 immediate, sb 0x3001.
    apply_stimulus(1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'h0, 2);
    idle_gap(1);
    apply_stimulus(1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'h0, 0);
    idle_gap(1);
    apply_stimulus(1'b1, 2'b00, 1'b0, 32'h0000_3001, 32'h0000_00A5, 1);
    idle_gap(1);
    // sw then lw to the same word, back to back.
    apply_stimulus(1'b1, 2'b10, 1'b0, 32'h0000_4000, 32'hCAFE_F00D, 0);
    apply_stimulus(1'b0, 2'b10, 1'b0, 32'h0000_4000, 32'h0, 1);
    idle_gap(1);
    // misaligned word load.
    apply_stimulus(1'b0, 2'b10, 1'b0, 32'h0000_5002, 32'h0, 0);
    idle_gap(1);

    // Reset in the middle of a BUSY access, followed by a stray ack.
    ram_hold = 1'b1;
    mem_req_mem      = 1'b1;
    mem_we_mem       = 1'b0;
    mem_size_mem     = 2'b10;
    mem_unsigned_mem = 1'b0;
    alu_c_mem        = 32'h0000_1004;
    @(negedge clk);
    check_output("rstbusy_idle_stall", 32'(mem_stall), 32'h1);
    @(negedge clk);
    check_output("rstbusy_req", 32'(dram_req), 32'h1);
    @(posedge clk);
    #1;
    rst         = 1'b1;
    mem_req_mem = 1'b0;
    @(negedge clk);
    check_output("rstbusy_stall_forced", 32'(mem_stall), 32'h0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    late_ack = 1'b1;
    last_rd  = 32'h0;
    @(negedge clk);
    check_output("rstbusy_req_dropped", 32'(dram_req), 32'h0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_output("late_ack_req", 32'(dram_req), 32'h0);
    check_output("late_ack_rd_mem", dram_rd_mem, 32'h0);
    check_output("late_ack_stall", 32'(mem_stall), 32'h0);
    @(posedge clk);
    #1;
    ram_hold = 1'b0;
    idle_gap(1);

    // Randomized traffic over a small window so loads hit earlier stores.
    for (int n = 0; n < 80; n++) begin
      apply_stimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                     32'h0000_1000 + 32'($urandom_range(0, 63)), $urandom, $urandom_range(0, 3));
      idle_gap($urandom_range(0, 2));
    end

    idle_gap(2);
    check_output("req_queue_drained", 32'(req_q.size()), 32'h0);
    check_output("res_queue_drained", 32'(res_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
